// File: rtl/sync_pkg.sv
// Shared types and constants for the board-sync phase alignment logic.
package sync_pkg;

  typedef enum logic [1:0] {
    ACQUIRE = 2'd0,
    TRACK   = 2'd1,
    LOCKED  = 2'd2
  } sync_state_e;

  // Cycles from sync_in to sync_rise through the synchronizer and edge detector.
  localparam int SYNC_LAT = 2;

  // A divider shorter than SYNC_LAT+2 leaves no room for the post-realign preset.
  function automatic logic div_is_legal(input int unsigned div);
    return div >= unsigned'(SYNC_LAT + 2);
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer followed by a rising-edge detector on the synchronized level.
module sync_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise
);

  localparam int STAGES = 3;

  logic [STAGES-1:0] stage_reg;
  logic [STAGES-1:0] stage_next;

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        assign stage_next[gi] = d;
      end else begin : g_follow
        assign stage_next[gi] = stage_reg[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      stage_reg <= '0;
    end else begin
      stage_reg <= stage_next;
    end
  end

  // Stage 2 only serves as the delayed copy for edge detection.
  assign rise = stage_reg[1] & ~stage_reg[2];

endmodule

// File: rtl/sync_phase_ctrl.sv
// Aligns the local divided-clock phase counter to an external board-sync pulse,
// sequencing acquire/track/lock and issuing preset strobes to the register bank.
module sync_phase_ctrl
  import sync_pkg::*;
#(
  parameter int DIV_WIDTH   = 8,
  parameter int DIV_DEFAULT = 100,
  parameter int LOCK_COUNT  = 4,
  parameter int MISS_LIMIT  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sync_in,
  input  logic                 cfg_valid,
  input  logic [DIV_WIDTH-1:0] cfg_div,
  output logic                 cfg_ready,
  output logic                 cfg_err,
  output logic [DIV_WIDTH-1:0] phase,
  output logic                 tick,
  output logic                 realign,
  output logic [DIV_WIDTH-1:0] realign_val,
  output logic                 locked,
  output logic [1:0]           state_o
);

  localparam int MATCH_W = (LOCK_COUNT > 1) ? $clog2(LOCK_COUNT) : 1;
  localparam int MISS_W  = (MISS_LIMIT > 1) ? $clog2(MISS_LIMIT) : 1;

  localparam logic [DIV_WIDTH-1:0] DIV_RESET   = DIV_WIDTH'(DIV_DEFAULT);
  localparam logic [DIV_WIDTH-1:0] PHASE_LAT   = DIV_WIDTH'(SYNC_LAT);
  // Every legal divider exceeds SYNC_LAT+1, so the modulo reduces to the constant.
  localparam logic [DIV_WIDTH-1:0] REALIGN_VAL = DIV_WIDTH'(SYNC_LAT + 1);
  localparam logic [MATCH_W-1:0]   MATCH_LAST  = MATCH_W'(LOCK_COUNT - 1);
  localparam logic [MISS_W-1:0]    MISS_LAST   = MISS_W'(MISS_LIMIT - 1);

  sync_state_e          state_reg, state_next;
  logic [DIV_WIDTH-1:0] phase_reg, phase_next;
  logic [DIV_WIDTH-1:0] div_reg, div_next;
  logic [MATCH_W-1:0]   match_cnt_reg, match_cnt_next;
  logic [MISS_W-1:0]    miss_cnt_reg, miss_cnt_next;
  logic                 locked_reg, locked_next;
  logic                 tick_reg, tick_next;
  logic                 realign_reg, realign_next;
  logic [DIV_WIDTH-1:0] realign_val_reg, realign_val_next;
  logic                 cfg_ready_reg, cfg_ready_next;
  logic                 cfg_err_reg, cfg_err_next;

  logic sync_rise;
  logic cfg_accept;
  logic cfg_legal;
  logic aligned;
  logic do_realign;

  sync_edge_det u_edge (
    .clk   (clk),
    .reset (reset),
    .d     (sync_in),
    .rise  (sync_rise)
  );

  assign cfg_accept = cfg_valid & cfg_ready_reg;
  assign cfg_legal  = div_is_legal(32'(cfg_div));
  assign aligned    = sync_rise && (phase_reg == PHASE_LAT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= ACQUIRE;
      phase_reg       <= '0;
      div_reg         <= DIV_RESET;
      match_cnt_reg   <= '0;
      miss_cnt_reg    <= '0;
      locked_reg      <= 1'b0;
      tick_reg        <= 1'b0;
      realign_reg     <= 1'b0;
      realign_val_reg <= '0;
      cfg_ready_reg   <= 1'b0;
      cfg_err_reg     <= 1'b0;
    end else begin
      state_reg       <= state_next;
      phase_reg       <= phase_next;
      div_reg         <= div_next;
      match_cnt_reg   <= match_cnt_next;
      miss_cnt_reg    <= miss_cnt_next;
      locked_reg      <= locked_next;
      tick_reg        <= tick_next;
      realign_reg     <= realign_next;
      realign_val_reg <= realign_val_next;
      cfg_ready_reg   <= cfg_ready_next;
      cfg_err_reg     <= cfg_err_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    phase_next       = (phase_reg == div_reg - 1'b1) ? '0 : phase_reg + 1'b1;
    div_next         = div_reg;
    match_cnt_next   = match_cnt_reg;
    miss_cnt_next    = miss_cnt_reg;
    locked_next      = locked_reg;
    realign_next     = 1'b0;
    realign_val_next = realign_val_reg;
    cfg_ready_next   = ~cfg_accept;
    cfg_err_next     = 1'b0;
    do_realign       = 1'b0;

    // A config accept pre-empts any sync event in the same cycle.
    if (cfg_accept) begin
      if (cfg_legal) begin
        div_next       = cfg_div;
        phase_next     = '0;
        state_next     = ACQUIRE;
        locked_next    = 1'b0;
        match_cnt_next = '0;
        miss_cnt_next  = '0;
      end else begin
        cfg_err_next = 1'b1;
      end
    end else begin
      case (state_reg)
        ACQUIRE: begin
          if (sync_rise) begin
            do_realign     = 1'b1;
            match_cnt_next = '0;
            miss_cnt_next  = '0;
            state_next     = TRACK;
          end
        end
        TRACK, LOCKED: begin
          if (sync_rise) begin
            miss_cnt_next = '0;
            if (aligned) begin
              if (state_reg == TRACK) begin
                if (match_cnt_reg == MATCH_LAST) begin
                  state_next  = LOCKED;
                  locked_next = 1'b1;
                end else begin
                  match_cnt_next = match_cnt_reg + 1'b1;
                end
              end
            end else begin
              do_realign     = 1'b1;
              match_cnt_next = '0;
              locked_next    = 1'b0;
              state_next     = TRACK;
            end
          end else if (tick_reg) begin
            if (miss_cnt_reg == MISS_LAST) begin
              state_next     = ACQUIRE;
              locked_next    = 1'b0;
              miss_cnt_next  = '0;
              match_cnt_next = '0;
            end else begin
              miss_cnt_next = miss_cnt_reg + 1'b1;
            end
          end
        end
        default: begin
          state_next  = ACQUIRE;
          locked_next = 1'b0;
        end
      endcase
    end

    if (do_realign) begin
      phase_next       = REALIGN_VAL;
      realign_next     = 1'b1;
      realign_val_next = REALIGN_VAL;
    end

    tick_next = (phase_next == '0);
  end

  assign cfg_ready   = cfg_ready_reg;
  assign cfg_err     = cfg_err_reg;
  assign phase       = phase_reg;
  assign tick        = tick_reg;
  assign realign     = realign_reg;
  assign realign_val = realign_val_reg;
  assign locked      = locked_reg;
  assign state_o     = state_reg;

endmodule

// File: tb/tb_sync_phase_ctrl.sv
// Scoreboard bench for sync_phase_ctrl: stimulus queues expected events, a monitor checks them.
module tb_sync_phase_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         sync_in = 1'b0;
  logic         cfg_valid = 1'b0;
  logic [W-1:0] cfg_div = '0;
  logic         cfg_ready;
  logic         cfg_err;
  logic [W-1:0] phase;
  logic         tick;
  logic         realign;
  logic [W-1:0] realign_val;
  logic         locked;
  logic [1:0]   state_o;

  sync_phase_ctrl #(
    .DIV_WIDTH   (W),
    .DIV_DEFAULT (10),
    .LOCK_COUNT  (4),
    .MISS_LIMIT  (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sync_in     (sync_in),
    .cfg_valid   (cfg_valid),
    .cfg_div     (cfg_div),
    .cfg_ready   (cfg_ready),
    .cfg_err     (cfg_err),
    .phase       (phase),
    .tick        (tick),
    .realign     (realign),
    .realign_val (realign_val),
    .locked      (locked),
    .state_o     (state_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int val;
  } evt_t;

  typedef struct {
    int    cyc;
    int    phase;
    int    tick;
    int    locked;
    int    state;
    int    ready;
    string name;
  } snap_t;

  evt_t  realign_q[$];
  int    err_q[$];
  snap_t snap_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step();
  endtask

  task automatic sync_at(input int c);
    wait_until(c);
    sync_in = 1'b1;
    step();
    sync_in = 1'b0;
  endtask

  task automatic push_realign(input int c, input int v);
    evt_t e;
    e.cyc = c;
    e.val = v;
    realign_q.push_back(e);
  endtask

  // Field value -1 means "not checked" for that snapshot.
  task automatic expect_snap(input int c, input int ph, input int tk, input int lk,
                             input int st, input int rd, input string nm);
    snap_t s;
    s.cyc = c; s.phase = ph; s.tick = tk; s.locked = lk;
    s.state = st; s.ready = rd; s.name = nm;
    snap_q.push_back(s);
  endtask

  always @(negedge clk) begin
    evt_t  e;
    snap_t s;
    int    ec;
    while (realign_q.size() > 0 && realign_q[0].cyc < cyc) begin
      e = realign_q.pop_front();
      check("realign_missing", 0, 1);
    end
    if (realign === 1'b1) begin
      if (realign_q.size() == 0) begin
        check("realign_unexpected", 1, 0);
      end else begin
        e = realign_q.pop_front();
        check("realign_cycle", cyc, e.cyc);
        check("realign_val", int'(realign_val), e.val);
      end
    end
    while (err_q.size() > 0 && err_q[0] < cyc) begin
      ec = err_q.pop_front();
      check("cfg_err_missing", 0, 1);
    end
    if (cfg_err === 1'b1) begin
      if (err_q.size() == 0) begin
        check("cfg_err_unexpected", 1, 0);
      end else begin
        ec = err_q.pop_front();
        check("cfg_err_cycle", cyc, ec);
      end
    end
    while (snap_q.size() > 0 && snap_q[0].cyc <= cyc) begin
      s = snap_q.pop_front();
      if (s.cyc < cyc) begin
        check({s.name, "_missed"}, cyc, s.cyc);
      end else begin
        if (s.phase  >= 0) check({s.name, "_phase"},  int'(phase),   s.phase);
        if (s.tick   >= 0) check({s.name, "_tick"},   int'(tick),    s.tick);
        if (s.locked >= 0) check({s.name, "_locked"}, int'(locked),  s.locked);
        if (s.state  >= 0) check({s.name, "_state"},  int'(state_o), s.state);
        if (s.ready  >= 0) check({s.name, "_ready"},  int'(cfg_ready), s.ready);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset release and free-running count (div 10; phase 0 at cycle 3).
    expect_snap(3, 0, 0, 0, 0, 0, "reset");
    expect_snap(4, 1, 0, 0, 0, 1, "rst_release");
    expect_snap(12, 9, 0, 0, 0, 1, "phase9");
    expect_snap(13, 0, 1, 0, 0, 1, "wrap");
    expect_snap(14, 1, 0, -1, -1, -1, "after_wrap");
    wait_until(3);
    reset = 1'b0;

    // First sync: rise in cycle 17, preset 3 in cycle 18.
    push_realign(18, 3);
    expect_snap(17, 4, -1, 0, 0, -1, "pre_acq");
    expect_snap(18, 3, 0, 0, 1, -1, "acquire");
    sync_at(15);

    // Four aligned pulses (phase 0 at 25,35,45,55) lock at cycle 58.
    expect_snap(25, 0, 1, 0, 1, -1, "track_tick");
    expect_snap(57, 2, -1, 0, 1, -1, "pre_lock");
    expect_snap(58, 3, -1, 1, 2, -1, "lock");
    for (int i = 0; i < 4; i++) sync_at(25 + 10 * i);
    sync_at(65);

    // Sync three cycles early while locked: misaligned rise at phase 9.
    push_realign(75, 3);
    expect_snap(74, 9, -1, 1, 2, -1, "early_rise");
    expect_snap(75, 3, 0, 0, 1, -1, "early_realign");
    sync_at(72);

    // Relock after four further aligned pulses.
    expect_snap(114, 2, -1, 0, 1, -1, "pre_relock");
    expect_snap(115, 3, -1, 1, 2, -1, "relock");
    for (int i = 0; i < 4; i++) sync_at(82 + 10 * i);

    // Sync stops: ticks at 122,132,142,152 drop back to ACQUIRE.
    expect_snap(152, 0, 1, 1, 2, -1, "miss_4th_tick");
    expect_snap(153, 1, 0, 0, 0, -1, "miss_limit");

    // Illegal divider 3: error pulse, divider stays 10.
    err_q.push_back(156);
    expect_snap(156, 4, -1, 0, 0, 0, "cfg_bad");
    expect_snap(157, 5, -1, -1, 0, 1, "cfg_bad_ready");
    expect_snap(162, 0, 1, 0, 0, 1, "div_kept");
    wait_until(155);
    cfg_valid = 1'b1;
    cfg_div   = 8'd3;
    step();
    cfg_valid = 1'b0;
    cfg_div   = '0;

    // Divider 20 accepted in the same cycle as sync_rise (cycle 167).
    expect_snap(167, 5, -1, 0, 0, 1, "collide_pre");
    expect_snap(168, 0, 1, 0, 0, 0, "cfg_ok");
    expect_snap(178, 10, 0, 0, 0, 1, "div20_mid");
    expect_snap(187, 19, 0, 0, 0, 1, "div20_end");
    expect_snap(188, 0, 1, 0, 0, 1, "div20_wrap");
    sync_at(165);
    wait_until(167);
    cfg_valid = 1'b1;
    cfg_div   = 8'd20;
    step();
    cfg_valid = 1'b0;
    cfg_div   = '0;

    // Reacquire under the new period.
    push_realign(193, 3);
    expect_snap(193, 3, 0, 0, 1, 1, "reacquire");
    sync_at(190);

    // Reset mid-operation drops the realign a pending sync would have caused.
    expect_snap(196, 0, 0, 0, 0, 0, "mid_reset");
    expect_snap(197, 1, 0, 0, 0, 1, "post_reset");
    sync_at(194);
    reset = 1'b1;
    step();
    reset = 1'b0;

    wait_until(205);
    for (int i = 0; i < realign_q.size(); i++) check("realign_leftover", 0, 1);
    for (int i = 0; i < err_q.size(); i++) check("cfg_err_leftover", 0, 1);
    for (int i = 0; i < snap_q.size(); i++) check({snap_q[i].name, "_leftover"}, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sync_phase_ctrl.md
Name: sync_phase_ctrl

Overview:
- Aligns the local divided-clock phase counter to an external board-sync pulse.
- Sequences acquire, track and lock, and issues one-cycle realign strobes with a preset value for the downstream preset-able register bank.
- Sits between the sync input pin and the per-board timing datapath in the synced-clocks top level.
- Divider period is runtime-configurable via a valid/ready handshake.

Parameters:
- DIV_WIDTH, 8: width of the phase counter and divider config.
- DIV_DEFAULT, 100: divider period loaded at reset; must satisfy SYNC_LAT+2 <= DIV_DEFAULT < 2^DIV_WIDTH.
- SYNC_LAT, 2: pipeline latency of sync_in to sync_rise, in clk cycles; fixed by the synchronizer design.
- LOCK_COUNT, 4: consecutive aligned sync pulses required to assert locked.
- MISS_LIMIT, 4: consecutive ticks without a sync pulse before falling back to ACQUIRE.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- sync_in  in  1  asynchronous external sync pulse; min high width 1 clk.
- cfg_valid  in  1  divider config request.
- cfg_div  in  DIV_WIDTH  requested divider period.
- cfg_ready  out  1  config accept.
- cfg_err  out  1  one-cycle pulse on an accepted but illegal cfg_div.
- phase  out  DIV_WIDTH  local phase counter, 0..div-1.
- tick  out  1  one-cycle pulse in each cycle where phase==0.
- realign  out  1  one-cycle preset strobe.
- realign_val  out  DIV_WIDTH  value written to phase on realign; held stable while realign=1.
- locked  out  1  phase-lock indicator.
- state_o  out  2  current FSM state, for debug.

Behaviour:
- Reset values: phase=0, div_reg=DIV_DEFAULT, state=ACQUIRE, locked=0, tick=0, realign=0, realign_val=0, cfg_ready=0, cfg_err=0, match_cnt=0, miss_cnt=0, synchronizer flops=0.
- cfg_ready rises in the first cycle after reset deasserts.
- Synchronizer: s1<=sync_in, s2<=s1, s3<=s2. sync_rise = s2 & ~s3, combinational. If sync_in is high at reset release, a sync_rise occurs 2 cycles later; this is intended.
- Phase counter: phase <= (phase==div_reg-1) ? 0 : phase+1, except on realign or cfg accept. tick is registered: tick=1 in each cycle where phase==0.
- Aligned sync: sync_rise while phase==SYNC_LAT.
- Realign action: phase <= (SYNC_LAT+1) mod div_reg. In the same cycle, realign<=1 and realign_val<=that value. A realign costs no extra latency; the counter continues from the preset on the next edge.
- FSM encoding: ACQUIRE=0, TRACK=1, LOCKED=2.
- ACQUIRE:
  - On sync_rise: realign, match_cnt<=0, miss_cnt<=0, go to TRACK.
  - Otherwise the counter free-runs.
- TRACK:
  - Aligned sync: match_cnt++. When match_cnt==LOCK_COUNT-1, go to LOCKED and set locked<=1.
  - Misaligned sync: realign, match_cnt<=0.
- LOCKED:
  - Aligned sync: stay in LOCKED.
  - Misaligned sync: realign, locked<=0, match_cnt<=0, go to TRACK.
- Miss counting (TRACK/LOCKED):
  - miss_cnt increments on each tick and clears on any sync_rise.
  - When miss_cnt reaches MISS_LIMIT: go to ACQUIRE, locked<=0, miss_cnt<=0.
  - If tick and sync_rise occur in the same cycle, sync_rise wins and miss_cnt clears.
- Config handshake:
  - Accept on cfg_valid & cfg_ready. cfg_ready is low for the single cycle following each acceptance.
  - Legal when SYNC_LAT+2 <= cfg_div. On a legal accept: div_reg<=cfg_div, phase<=0, state<=ACQUIRE, locked<=0, counters cleared.
  - On an illegal accept: cfg_err pulses for 1 cycle; div_reg and state are unchanged.
- Simultaneous cfg accept and sync_rise: the config wins; sync_rise is ignored; no realign is issued.
- Reset mid-operation: all state returns to reset values on the next edge, and any pending realign/tick is dropped.
- Outputs are registered except state_o, which is a direct state register view.

Decomposition:
- Shared package sync_pkg holds:
  - the state enum (ACQUIRE/TRACK/LOCKED);
  - SYNC_LAT;
  - the legality-check function for the divider value.
- One natural sub-module, sync_edge_det: 2-FF synchronizer plus rising-edge detect, with a synchronous reset. It is reusable for other external strobes.

Test Plan (DIV_DEFAULT=10, SYNC_LAT=2, LOCK_COUNT=4, MISS_LIMIT=4):
- Reset release, no sync: phase counts 0..9 and wraps; tick every 10 cycles; state_o=0; locked=0; cfg_ready=1 one cycle after reset deasserts.
- First sync_in pulse: sync_rise 2 cycles later; realign=1 with realign_val=3; phase=3 on the next cycle; state_o=1.
- Periodic sync every 10 cycles after acquire: four aligned pulses (phase==2 at each sync_rise) then locked=1 and state_o=2; no further realign.
- While locked, one sync arrives 3 cycles early: realign with realign_val=3, locked=0, state_o=1; relock after 4 further aligned pulses.
- While locked, stop sync: after 4 ticks, state_o=0 and locked=0; a cfg_div=3 request gets cfg_err=1 and div stays 10.
- cfg_div=20 accepted in the same cycle as sync_rise: no realign, phase=0, state_o=0, period now 20; a later sync reacquires with realign_val=3.
